// File: rtl/inst_sram_like_responder.sv
// inst_sram_like_responder: sram-like bus slave with internal word RAM and in-order fixed-latency responses
module inst_sram_like_responder #(
  parameter int    AW        = 14,
  parameter int    DEPTH     = 4,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        hold,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int GW = $clog2(LATENCY + 1);

  logic [31:0]   r_mem [0:(1<<AW)-1];
  logic [31:0]   r_data [DEPTH];
  logic [GW-1:0] r_age [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd;
  logic          w_unused;

  // size and the sub-word / out-of-range address bits carry no meaning here
  assign w_unused = ^{size, addr[31:AW+2], addr[1:0]};
  assign w_idx    = addr[AW+1:2];
  assign addr_ok  = req && !hold && (r_count < CW'(DEPTH));
  assign w_push   = req && addr_ok && !reset;
  assign w_rd     = wr ? 32'h0 : r_mem[w_idx];
  assign data_ok  = (r_count != '0) && (r_age[r_head] >= GW'(LATENCY));
  assign rdata    = data_ok ? r_data[r_head] : 32'h0;

  // Byte-enabled RAM write at acceptance; contents survive reset
  always_ff @(posedge clk) begin
    if (w_push && wr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  // Queue pointers and occupancy; reset drops every in-flight response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (data_ok) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(data_ok);
    end
  end

  // Entry payload capture and saturating age; validity comes from r_count
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && r_tail == PW'(i)) begin
        r_data[i] <= w_rd;
        r_age[i]  <= GW'(1);
      end else if (r_age[i] < GW'(LATENCY)) begin
        r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_sram_like_responder.sv
// tb_inst_sram_like_responder: directed checks of acceptance, latency, ordering, byte writes, hold and reset
module tb_inst_sram_like_responder;
  logic        clk = 0;
  logic        reset = 1;
  logic        req = 0;
  logic        req8 = 0;
  logic        wr = 0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic        hold = 0;
  logic        addr_ok, data_ok, addr_ok8, data_ok8;
  logic [31:0] rdata, rdata8;
  int          n_cmp = 0;
  int          n_bad = 0;

  inst_sram_like_responder #(.AW(14), .DEPTH(4), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .hold(hold),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  inst_sram_like_responder #(.AW(14), .DEPTH(4), .LATENCY(8)) u_dut8 (
    .clk(clk), .reset(reset), .req(req8), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .hold(hold),
    .addr_ok(addr_ok8), .data_ok(data_ok8), .rdata(rdata8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  logic [31:0] pre [5];
  logic [31:0] exp_rd;
  int          a;
  int          r;
  bit          exp_aok;
  bit          exp_dok;

  initial begin
    pre[0] = 32'h02800c0c;
    pre[1] = 32'h11111111;
    pre[2] = 32'h22222222;
    pre[3] = 32'h33333333;
    pre[4] = 32'h11223344;
    nxt;
    nxt;
    smp;
    chk("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
    chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 0;
    nxt;
    // preload words 0..4 of the LATENCY=2 instance
    wr = 1;
    wstrb = 4'hf;
    for (int i = 0; i < 5; i++) begin
      req = 1;
      addr = 32'(i * 4);
      wdata = pre[i];
      nxt;
    end
    req = 0;
    wr = 0;
    repeat (4) nxt;
    // test 1: single read of 0x1c000000 aliasing word 0
    req = 1;
    addr = 32'h1c000000;
    smp;
    chk("t1_aok", {31'b0, addr_ok}, 32'd1);
    chk("t1_dok_c0", {31'b0, data_ok}, 32'd0);
    nxt;
    req = 0;
    smp;
    chk("t1_dok_c1", {31'b0, data_ok}, 32'd0);
    nxt;
    smp;
    chk("t1_dok_c2", {31'b0, data_ok}, 32'd1);
    chk("t1_rdata", rdata, 32'h02800c0c);
    nxt;
    smp;
    chk("t1_dok_c3", {31'b0, data_ok}, 32'd0);
    chk("t1_rdata_idle", rdata, 32'h0);
    nxt;
    // test 2: back-to-back reads of words 0..3
    for (int k = 0; k < 7; k++) begin
      req = (k < 4);
      addr = 32'(k * 4);
      smp;
      if (k < 4) chk("t2_aok", {31'b0, addr_ok}, 32'd1);
      chk("t2_dok", {31'b0, data_ok}, {31'b0, (k >= 2 && k < 6)});
      chk("t2_rdata", rdata, (k >= 2 && k < 6) ? pre[k-2] : 32'h0);
      chk("t2_cnt_le2", {31'b0, (u_dut.r_count <= 3'd2)}, 32'd1);
      nxt;
    end
    req = 0;
    // test 4: partial write then read of the same word
    req = 1;
    wr = 1;
    addr = 32'h10;
    wdata = 32'haabbccdd;
    wstrb = 4'b0101;
    nxt;
    wr = 0;
    wstrb = 4'h0;
    nxt;
    req = 0;
    smp;
    chk("t4_wr_dok", {31'b0, data_ok}, 32'd1);
    chk("t4_wr_rdata", rdata, 32'h0);
    nxt;
    smp;
    chk("t4_rd_dok", {31'b0, data_ok}, 32'd1);
    chk("t4_rd_rdata", rdata, 32'h11bb33dd);
    nxt;
    // test 5: hold stalls acceptance
    req = 1;
    hold = 1;
    addr = 32'h4;
    for (int k = 0; k < 3; k++) begin
      smp;
      chk("t5_hold_aok", {31'b0, addr_ok}, 32'd0);
      chk("t5_hold_dok", {31'b0, data_ok}, 32'd0);
      nxt;
    end
    hold = 0;
    smp;
    chk("t5_release_aok", {31'b0, addr_ok}, 32'd1);
    nxt;
    req = 0;
    smp;
    chk("t5_dok_c1", {31'b0, data_ok}, 32'd0);
    nxt;
    smp;
    chk("t5_dok_c2", {31'b0, data_ok}, 32'd1);
    chk("t5_rdata", rdata, 32'h11111111);
    nxt;
    // test 3: LATENCY=8 instance, preload words 0..5 then 6 back-to-back reads
    wr = 1;
    wstrb = 4'hf;
    for (int i = 0; i < 6; i++) begin
      req8 = 1;
      addr = 32'(i * 4);
      wdata = 32'ha0000000 + 32'(i);
      nxt;
      req8 = 0;
      repeat (9) nxt;
    end
    wr = 0;
    wstrb = 4'h0;
    a = 0;
    r = 0;
    for (int k = 0; k < 20; k++) begin
      req8 = (k <= 10);
      addr = 32'(a * 4);
      exp_aok = (k < 4) || (k == 9) || (k == 10);
      exp_dok = (k >= 8 && k <= 11) || k == 17 || k == 18;
      exp_rd = exp_dok ? 32'ha0000000 + 32'(r) : 32'h0;
      smp;
      chk("t3_aok", {31'b0, addr_ok8}, {31'b0, exp_aok});
      chk("t3_dok", {31'b0, data_ok8}, {31'b0, exp_dok});
      chk("t3_rdata", rdata8, exp_rd);
      if (exp_aok) a++;
      if (exp_dok) r++;
      nxt;
    end
    req8 = 0;
    // test 6: reset with three responses in flight, write persists
    req8 = 1;
    wr = 1;
    wstrb = 4'hf;
    addr = 32'h18;
    wdata = 32'h66666666;
    nxt;
    wr = 0;
    wstrb = 4'h0;
    addr = 32'h0;
    nxt;
    addr = 32'h4;
    nxt;
    req8 = 0;
    reset = 1;
    smp;
    chk("t6_rst_dok", {31'b0, data_ok8}, 32'd0);
    nxt;
    reset = 0;
    for (int k = 0; k < 12; k++) begin
      smp;
      chk("t6_post_dok", {31'b0, data_ok8}, 32'd0);
      nxt;
    end
    req8 = 1;
    addr = 32'h18;
    for (int k = 0; k < 10; k++) begin
      smp;
      if (k == 0) chk("t6_aok", {31'b0, addr_ok8}, 32'd1);
      chk("t6_dok", {31'b0, data_ok8}, {31'b0, (k == 8)});
      chk("t6_rdata", rdata8, (k == 8) ? 32'h66666666 : 32'h0);
      nxt;
      req8 = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
